tapasco_dmi_sequencer: RTL
==========================

Name: tapasco_dmi_sequencer

Overview:
Converts the TaPaSCo host's level-style DMI register interface (req/wr/addr/wdata) into exactly one valid/ready DMI request per host request, then collects the matching DMI response. It sits between the host register file and the debug module's DMI request/response ports. It adds rising-edge launch detection, response capture and holding, a busy/done/error status, and a response timeout.

Parameters:
TIMEOUT_CYCLES, 1024, maximum cycles spent in REQ or RESP before abort; 0 disables the timeout.
CNT_W, $clog2(TIMEOUT_CYCLES+1) (minimum 1), width of the timeout counter.

Ports:
clk_i  in  1  clock; single clock domain.
rst_i  in  1  asynchronous, active-high reset.
host_req_i  in  1  level request from the host; a rising edge launches one transaction.
host_wr_i  in  1  1 = write, 0 = read; sampled at launch.
host_addr_i  in  7  DMI address; sampled at launch.
host_wdata_i  in  32  DMI write data; sampled at launch.
host_rdata_o  out  32  captured response data, held until the next capture.
host_resp_o  out  2  captured DMI response code (0 = ok).
host_busy_o  out  1  transaction in flight.
host_done_o  out  1  sticky completion flag.
host_err_o  out  1  sticky timeout flag.
host_ovr_o  out  1  sticky flag: a launch edge arrived while busy.
dmi_req_valid_o  out  1  DMI request valid.
dmi_req_ready_i  in  1  DMI request ready.
dmi_req_op_o  out  2  0 = NOP, 1 = READ, 2 = WRITE.
dmi_req_addr_o  out  7  DMI request address.
dmi_req_data_o  out  32  DMI request data.
dmi_resp_valid_i  in  1  DMI response valid.
dmi_resp_ready_o  out  1  DMI response ready.
dmi_resp_data_i  in  32  DMI response data.
dmi_resp_resp_i  in  2  DMI response code.

Behaviour:
- Reset values: all outputs 0; dmi_req_op_o = NOP (0); state = IDLE; counter = 0; the registered previous value of host_req_i = 0.
- Launch condition: host_req_i == 1, previous sample == 0, and state == IDLE.
  - On launch: op/addr/data are registered from the host inputs.
  - On launch: done, err and ovr are cleared.
  - If host_req_i is already high when reset releases, nothing launches; the edge detector needs a 0 sample first.
- State IDLE:
  - dmi_req_valid_o = 0; dmi_req_op_o = NOP.
  - Launch moves to REQ on the next cycle.
  - Launch latency: dmi_req_valid_o rises 1 cycle after the host_req_i edge.
- State REQ:
  - dmi_req_valid_o = 1; op/addr/data stay stable until the handshake.
  - valid && ready: go to RESP; valid drops the next cycle; op returns to NOP.
- State RESP:
  - dmi_resp_ready_o = 1.
  - On dmi_resp_valid_i: capture data into host_rdata_o and code into host_resp_o, set host_done_o, return to IDLE.
  - The captured values appear the cycle after the handshake.
- Response in the same cycle as the request handshake: ignored, because ready is low in REQ. The debug module holds its response valid, so it is accepted in RESP.
- host_busy_o = 1 in REQ and RESP.
- Timeout counter:
  - Clears on every state entry and increments each cycle in REQ/RESP.
  - When it reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0): set host_err_o and host_done_o, keep host_rdata_o unchanged, set host_resp_o = 2'b10, drop valid/ready, go to IDLE.
  - A handshake in the same cycle as the timeout wins: completes normally, no error.
- Launch edge while busy: ignored, host_ovr_o set. No queueing.
- host_req_i falling mid-transaction: no effect; the transaction completes.
- Holding host_req_i high after done: no relaunch; a new 0→1 edge is required.
- Reset mid-transaction: returns immediately to IDLE with all outputs cleared; any outstanding DMI response is dropped.

Test Plan:
- Read: pulse host_req_i with wr = 0, addr = 0x11; DM ready on the first cycle; response data 0xDEADBEEF, code 0 after 3 cycles → exactly one valid cycle with op = 1, addr = 0x11; host_rdata_o = 0xDEADBEEF; done = 1; busy low.
- Write with backpressure: wr = 1, addr = 0x10, wdata = 0x00000001; ready held low 5 cycles → valid held 6 cycles with stable op = 2 and data; exactly one handshake; done after the response.
- Level hold: keep host_req_i high for 50 cycles → exactly one DMI request; after host_req_i falls and rises again → a second request.
- Overrun: a second rising edge while in RESP → host_ovr_o = 1; no extra request; the first transaction completes; ovr clears on the next launch.
- Timeout: TIMEOUT_CYCLES = 8, no response ever → err = 1, done = 1, host_resp_o = 2, host_rdata_o keeps its old value, state returns to IDLE; a following normal read succeeds with err cleared.
- Reset: assert rst_i while in REQ → valid = 0 asynchronously, all flags 0; after release with host_req_i held high → no launch until an edge.

Source files
------------

// File: rtl/tapasco_dmi_sequencer.sv
// TaPaSCo host register bridge to the debug module DMI port.
// One DMI request per host rising edge, with response capture and timeout.
module tapasco_dmi_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W =
    (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        host_req_i,
  input  logic        host_wr_i,
  input  logic [6:0]  host_addr_i,
  input  logic [31:0] host_wdata_i,
  output logic [31:0] host_rdata_o,
  output logic [1:0]  host_resp_o,
  output logic        host_busy_o,
  output logic        host_done_o,
  output logic        host_err_o,
  output logic        host_ovr_o,
  output logic        dmi_req_valid_o,
  input  logic        dmi_req_ready_i,
  output logic [1:0]  dmi_req_op_o,
  output logic [6:0]  dmi_req_addr_o,
  output logic [31:0] dmi_req_data_o,
  input  logic        dmi_resp_valid_i,
  output logic        dmi_resp_ready_o,
  input  logic [31:0] dmi_resp_data_i,
  input  logic [1:0]  dmi_resp_resp_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] RESP_TMO = 2'b10;

  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT_CYCLES);

  state_t state_q;
  state_t state_d;

  logic             req_q;
  logic             armed_q;
  logic [1:0]       op_q;
  logic [6:0]       addr_q;
  logic [31:0]      data_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      rdata_q;
  logic [1:0]       resp_q;
  logic             done_q;
  logic             err_q;
  logic             ovr_q;

  logic rise;
  logic busy;
  logic launch;
  logic req_hs;
  logic resp_hs;
  logic timeout;
  logic abort;

  // armed_q blocks a launch until host_req_i has been seen low after reset
  assign rise    = host_req_i & ~req_q & armed_q;
  assign busy    = (state_q != IDLE);
  assign launch  = rise & (state_q == IDLE);
  assign req_hs  = (state_q == REQ) & dmi_req_ready_i;
  assign resp_hs = (state_q == RESP) & dmi_resp_valid_i;
  assign timeout = TMO_EN & busy & (cnt_q == TMO_VAL);
  assign abort   = timeout & ~req_hs & ~resp_hs;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (launch) state_d = REQ;
      end
      REQ: begin
        if (req_hs)     state_d = RESP;
        else if (abort) state_d = IDLE;
      end
      RESP: begin
        if (resp_hs)    state_d = IDLE;
        else if (abort) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_q   <= 1'b0;
      armed_q <= 1'b0;
      op_q    <= OP_NOP;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      resp_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      req_q <= host_req_i;
      if (!host_req_i) armed_q <= 1'b1;

      if (launch) begin
        op_q   <= host_wr_i ? OP_WRITE : OP_READ;
        addr_q <= host_addr_i;
        data_q <= host_wdata_i;
        done_q <= 1'b0;
        err_q  <= 1'b0;
        ovr_q  <= 1'b0;
      end

      if (rise && busy) ovr_q <= 1'b1;

      if (resp_hs) begin
        rdata_q <= dmi_resp_data_i;
        resp_q  <= dmi_resp_resp_i;
        done_q  <= 1'b1;
      end else if (abort) begin
        resp_q <= RESP_TMO;
        done_q <= 1'b1;
        err_q  <= 1'b1;
      end

      if (state_d != state_q) cnt_q <= '0;
      else if (busy)          cnt_q <= cnt_q + 1'b1;
    end
  end

  assign dmi_req_valid_o  = (state_q == REQ);
  assign dmi_resp_ready_o = (state_q == RESP);
  assign dmi_req_op_o     = dmi_req_valid_o ? op_q : OP_NOP;
  assign dmi_req_addr_o   = addr_q;
  assign dmi_req_data_o   = data_q;

  assign host_rdata_o = rdata_q;
  assign host_resp_o  = resp_q;
  assign host_busy_o  = busy;
  assign host_done_o  = done_q;
  assign host_err_o   = err_q;
  assign host_ovr_o   = ovr_q;

endmodule
